// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU and its multiplier.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_PASSA = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// done is asserted in the last iteration cycle with product already final.
module seq_mul_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Product is exposed combinationally so the top can register it on the final edge.
  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered 8-op ALU with valid/ready on both sides; MUL runs on the iterative unit.
// out_valid is the HOLD state; single-cycle ops can hand off on the same edge.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               zero,
  output logic               carry
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;

  logic               accept, is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] ea, eb, sum, diff, alu_y;
  logic               alu_c;

  assign accept = in_valid && in_ready;
  assign is_mul = (s == OP_MUL);

  seq_mul_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_mul ? ST_BUSY : ST_HOLD;
      ST_BUSY: if (mul_done) state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          if (accept) state_d = is_mul ? ST_BUSY : ST_HOLD;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    out_valid = (state_q == ST_HOLD);
  end

  // Operands zero-extended to the result width; SUB wraps modulo 2^(2*WIDTH).
  assign ea   = {{WIDTH{1'b0}}, a};
  assign eb   = {{WIDTH{1'b0}}, b};
  assign sum  = ea + eb;
  assign diff = ea - eb;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    case (s)
      OP_ADD:   begin alu_y = sum;  alu_c = sum[WIDTH]; end
      OP_SUB:   begin alu_y = diff; alu_c = (a < b);    end
      OP_AND:   alu_y = ea & eb;
      OP_OR:    alu_y = ea | eb;
      OP_PASSA: alu_y = ea;
      OP_PASSB: alu_y = eb;
      OP_XOR:   alu_y = ea ^ eb;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    y_d     = y_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (accept && !is_mul) begin
      y_d     = alu_y;
      zero_d  = (alu_y == '0);
      carry_d = alu_c;
    end else if (mul_done) begin
      y_d     = mul_product;
      zero_d  = (mul_product == '0);
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign y     = y_q;
  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed WIDTH=4 scenarios plus a randomized WIDTH=8 scoreboard sweep with stalls.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b0, iv4 = 1'b0, or4 = 1'b0;
  logic       ir4, ov4, z4, c4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] s4 = '0;
  logic [7:0] y4;

  logic        rst8 = 1'b0, iv8 = 1'b0, or8 = 1'b0;
  logic        ir8, ov8, z8, c8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  s8 = '0;
  logic [15:0] y8;

  int asserts = 0;
  int fails   = 0;

  typedef struct {
    logic [15:0] y;
    logic        z;
    logic        c;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .s(s4),
    .out_valid(ov4), .out_ready(or4), .y(y4), .zero(z4), .carry(c4)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .s(s8),
    .out_valid(ov8), .out_ready(or8), .y(y8), .zero(z8), .carry(c8)
  );

  function automatic exp_t golden(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic [2:0] s);
    exp_t   e;
    longint ea = longint'(a);
    longint eb = longint'(b);
    longint m  = (longint'(1) << (2 * w)) - 1;
    longint r  = 0;
    logic   c  = 1'b0;
    case (s)
      3'd0: begin r = ea + eb; c = ((ea + eb) >> w) != 0; end
      3'd1: begin r = ea - eb; c = (ea < eb); end
      3'd2: r = ea & eb;
      3'd3: r = ea | eb;
      3'd4: r = ea * eb;
      3'd5: r = ea;
      3'd6: r = eb;
      default: r = ea ^ eb;
    endcase
    r   = r & m;
    e.y = 16'(r);
    e.z = (r == 0);
    e.c = c;
    return e;
  endfunction

  task automatic test_reset();
    #1;
    rst4 = 1'b1; rst8 = 1'b1;
    repeat (2) @(negedge clk);
    asserts++; if (ov4 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", ov4); end
    asserts++; if (y4 !== 8'h00) begin fails++; $display("FAIL reset_y got %h want 00", y4); end
    asserts++; if (z4 !== 1'b0 || c4 !== 1'b0) begin fails++; $display("FAIL reset_flags got z=%0b c=%0b want 0 0", z4, c4); end
    asserts++; if (ov8 !== 1'b0 || y8 !== 16'h0) begin fails++; $display("FAIL reset_w8 got ov=%0b y=%h want 0 0000", ov8, y8); end
    rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    asserts++; if (ir4 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", ir4); end
  endtask

  task automatic test_add();
    a4 = 4'd9; b4 = 4'd7; s4 = 3'b000; iv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    asserts++; if (ov4 !== 1'b1) begin fails++; $display("FAIL add_valid got %0b want 1", ov4); end
    asserts++; if (y4 !== 8'h10 || c4 !== 1'b1 || z4 !== 1'b0) begin
      fails++; $display("FAIL add_9_7 got y=%h c=%0b z=%0b want 10 1 0", y4, c4, z4); end
    @(negedge clk);
    asserts++; if (ov4 !== 1'b0) begin fails++; $display("FAIL add_drop got %0b want 0", ov4); end
  endtask

  task automatic test_sub();
    a4 = 4'd3; b4 = 4'd5; s4 = 3'b001; iv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    asserts++; if (y4 !== 8'hFE || c4 !== 1'b1 || z4 !== 1'b0) begin
      fails++; $display("FAIL sub_3_5 got y=%h c=%0b z=%0b want fe 1 0", y4, c4, z4); end
    a4 = 4'd5; b4 = 4'd5;
    @(negedge clk);
    iv4 = 1'b0;
    asserts++; if (y4 !== 8'h00 || z4 !== 1'b1 || c4 !== 1'b0) begin
      fails++; $display("FAIL sub_5_5 got y=%h z=%0b c=%0b want 00 1 0", y4, z4, c4); end
    @(negedge clk);
  endtask

  // MUL with a stalled sink; an ADD is held on the input during BUSY and must wait.
  task automatic test_mul();
    a4 = 4'd15; b4 = 4'd15; s4 = 3'b100; iv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    a4 = 4'd2; b4 = 4'd3; s4 = 3'b000; or4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      asserts++; if (ir4 !== 1'b0 || ov4 !== 1'b0) begin
        fails++; $display("FAIL mul_busy_%0d got ir=%0b ov=%0b want 0 0", i, ir4, ov4); end
      @(negedge clk);
    end
    asserts++; if (ov4 !== 1'b1 || y4 !== 8'hE1 || z4 !== 1'b0 || c4 !== 1'b0) begin
      fails++; $display("FAIL mul_15_15 got ov=%0b y=%h z=%0b c=%0b want 1 e1 0 0", ov4, y4, z4, c4); end
    @(negedge clk);
    asserts++; if (ov4 !== 1'b1 || y4 !== 8'hE1 || ir4 !== 1'b0) begin
      fails++; $display("FAIL mul_hold got ov=%0b y=%h ir=%0b want 1 e1 0", ov4, y4, ir4); end
    or4 = 1'b1;
    #1;
    asserts++; if (ir4 !== 1'b1) begin fails++; $display("FAIL mul_release_ready got %0b want 1", ir4); end
    @(negedge clk);
    iv4 = 1'b0;
    asserts++; if (ov4 !== 1'b1 || y4 !== 8'h05) begin
      fails++; $display("FAIL mul_then_add got ov=%0b y=%h want 1 05", ov4, y4); end
    @(negedge clk);
    asserts++; if (ov4 !== 1'b0) begin fails++; $display("FAIL mul_drop got %0b want 0", ov4); end
  endtask

  task automatic test_backpressure();
    a4 = 4'hA; b4 = 4'h5; s4 = 3'b111; iv4 = 1'b1; or4 = 1'b0;
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; s4 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      asserts++; if (ov4 !== 1'b1 || y4 !== 8'h0F || ir4 !== 1'b0) begin
        fails++; $display("FAIL bp_stall_%0d got ov=%0b y=%h ir=%0b want 1 0f 0", i, ov4, y4, ir4); end
      @(negedge clk);
    end
    or4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    asserts++; if (ov4 !== 1'b1 || y4 !== 8'h02) begin
      fails++; $display("FAIL bp_handoff got ov=%0b y=%h want 1 02", ov4, y4); end
    @(negedge clk);
    asserts++; if (ov4 !== 1'b0) begin fails++; $display("FAIL bp_drop got %0b want 0", ov4); end
  endtask

  task automatic test_reset_mid_mul();
    int n;
    a4 = 4'd15; b4 = 4'd15; s4 = 3'b100; iv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    asserts++; if (ov4 !== 1'b0 || y4 !== 8'h00) begin
      fails++; $display("FAIL rst_mid_mul got ov=%0b y=%h want 0 00", ov4, y4); end
    @(negedge clk);
    rst4 = 1'b0;
    repeat (5) @(negedge clk);
    asserts++; if (ov4 !== 1'b0) begin fails++; $display("FAIL rst_no_output got %0b want 0", ov4); end
    a4 = 4'd6; b4 = 4'd7; s4 = 3'b100; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    n = 0;
    while (ov4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    asserts++; if (n != 4) begin fails++; $display("FAIL mul_latency got %0d want 4", n); end
    asserts++; if (ov4 !== 1'b1 || y4 !== 8'h2A) begin
      fails++; $display("FAIL mul_6_7 got ov=%0b y=%h want 1 2a", ov4, y4); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    or4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = ops[i % 7]; iv4 = 1'b1;
      #1;
      asserts++; if (ir4 !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d got %0b want 1", i, ir4); end
      q4.push_back(golden(4, {4'b0, a4}, {4'b0, b4}, s4));
      @(negedge clk);
      e = q4.pop_front();
      asserts++; if (ov4 !== 1'b1 || y4 !== e.y[7:0] || z4 !== e.z || c4 !== e.c) begin
        fails++; $display("FAIL b2b_%0d got ov=%0b y=%h z=%0b c=%0b want 1 %h %0b %0b",
                          i, ov4, y4, z4, c4, e.y[7:0], e.z, e.c); end
    end
    iv4 = 1'b0;
    @(negedge clk);
    asserts++; if (ov4 !== 1'b0) begin fails++; $display("FAIL b2b_drop got %0b want 0", ov4); end
  endtask

  task automatic test_sweep_w8();
    exp_t        e;
    logic        took = 1'b0, stall = 1'b0;
    logic [15:0] sy = '0;
    logic        sz = 1'b0, sc = 1'b0;
    int          n;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!iv8 || took) begin
        iv8 = ($urandom_range(0, 9) < 8);
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        s8  = 3'($urandom_range(0, 7));
      end
      or8 = ($urandom_range(0, 9) < 7);
      #1;
      if (stall) begin
        asserts++; if (ov8 !== 1'b1 || y8 !== sy || z8 !== sz || c8 !== sc) begin
          fails++; $display("FAIL w8_stable cyc=%0d got ov=%0b y=%h want 1 %h", cyc, ov8, y8, sy); end
      end
      if (ov8 && or8) begin
        asserts++;
        if (q8.size() == 0) begin
          fails++; $display("FAIL w8_dup cyc=%0d got y=%h want no output", cyc, y8);
        end else begin
          e = q8.pop_front();
          if (y8 !== e.y || z8 !== e.z || c8 !== e.c) begin
            fails++; $display("FAIL w8_result cyc=%0d got y=%h z=%0b c=%0b want %h %0b %0b",
                              cyc, y8, z8, c8, e.y, e.z, e.c); end
        end
      end
      stall = ov8 && !or8;
      sy = y8; sz = z8; sc = c8;
      took = iv8 && ir8;
      if (took) q8.push_back(golden(8, a8, b8, s8));
      @(negedge clk);
    end
    iv8 = 1'b0; or8 = 1'b1;
    n = 0;
    while (q8.size() > 0 && n < 100) begin
      #1;
      if (ov8) begin
        e = q8.pop_front();
        asserts++; if (y8 !== e.y || z8 !== e.z || c8 !== e.c) begin
          fails++; $display("FAIL w8_drain got y=%h z=%0b c=%0b want %h %0b %0b", y8, z8, c8, e.y, e.z, e.c); end
      end
      @(negedge clk);
      n++;
    end
    asserts++; if (q8.size() != 0) begin fails++; $display("FAIL w8_lost got %0d pending want 0", q8.size()); end
    @(negedge clk);
    asserts++; if (ov8 !== 1'b0) begin fails++; $display("FAIL w8_extra got ov=%0b want 0", ov8); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_sweep_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
